// File: rtl/hi_lo_muldiv_if.sv
// hi_lo_muldiv_if: execute-stage <-> HI/LO mul/div unit connection.
//   clk_enable       global enable; all unit state holds when low
//   op_start/op_sel  issue request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_val/rt_val    multiplicand/dividend and multiplier/divisor
//   HI_*/LO_* input  MTHI/MTLO data and strobes
//   busy/done        op in flight / one-cycle completion pulse
//   HI/LO_output     architectural HI and LO registers
interface hi_lo_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             clk_enable;
    logic             op_start;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] HI_input;
    logic [WIDTH-1:0] LO_input;
    logic             HI_write_enable;
    logic             LO_write_enable;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI_output;
    logic [WIDTH-1:0] LO_output;

    modport master (
        output clk_enable, op_start, op_sel, rs_val, rt_val,
        output HI_input, LO_input, HI_write_enable, LO_write_enable,
        input  busy, done, HI_output, LO_output
    );

    modport slave (
        input  clk_enable, op_start, op_sel, rs_val, rt_val,
        input  HI_input, LO_input, HI_write_enable, LO_write_enable,
        output busy, done, HI_output, LO_output
    );
endinterface

// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit: HI/LO register pair with an iterative radix-2 multiply/divide engine.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    hi_lo_muldiv_if slave modport (issue, MTHI/MTLO, busy/done, HI/LO outputs)
// An op is accepted in IDLE, runs WIDTH steps in CALC, and writes HI/LO only in FIX.
module hi_lo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    hi_lo_muldiv_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 div_q;
    logic                 neg_res_q;   // quotient / product sign
    logic                 neg_rem_q;   // remainder sign (follows dividend)
    logic [WIDTH-1:0]     a_q;         // |multiplicand|
    logic [WIDTH-1:0]     b_q;         // |divisor|
    logic [WIDTH-1:0]     rs_q;        // raw dividend, needed for divide-by-zero HI
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    // Operand conditioning at acceptance
    logic                 is_signed;
    logic                 rs_neg;
    logic                 rt_neg;
    logic [WIDTH-1:0]     rs_abs;
    logic [WIDTH-1:0]     rt_abs;

    always_comb begin
        is_signed = ~bus.op_sel[0];
        rs_neg    = is_signed & bus.rs_val[WIDTH-1];
        rt_neg    = is_signed & bus.rt_val[WIDTH-1];
        rs_abs    = rs_neg ? (~bus.rs_val + WIDTH'(1)) : bus.rs_val;
        rt_abs    = rt_neg ? (~bus.rt_val + WIDTH'(1)) : bus.rt_val;
    end

    // One radix-2 step of each algorithm
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   div_next;

    always_comb begin
        // Shift-add: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = rem_sh >= {1'b0, b_q};
        // When div_ge the difference is below b_q, so the low WIDTH bits are exact
        rem_new  = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};
    end

    // Sign fix-up applied in FIX
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        prod   = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        quo    = acc_q[WIDTH-1:0];
        rem    = acc_q[2*WIDTH-1:WIDTH];
        if (!div_q) begin
            {fix_hi, fix_lo} = prod;
        end else if (b_q == '0) begin
            fix_hi = rs_q;
            fix_lo = '1;
        end else begin
            // Most-negative / -1 falls out naturally: |q| = 2^(W-1), negated wraps to itself
            fix_lo = neg_res_q ? (~quo + WIDTH'(1)) : quo;
            fix_hi = neg_rem_q ? (~rem + WIDTH'(1)) : rem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rs_q      <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.clk_enable) begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.op_start) begin
                        // op_start wins over any same-cycle MTHI/MTLO
                        div_q     <= bus.op_sel[1];
                        neg_res_q <= rs_neg ^ rt_neg;
                        neg_rem_q <= rs_neg;
                        a_q       <= rs_abs;
                        b_q       <= rt_abs;
                        rs_q      <= bus.rs_val;
                        acc_q     <= bus.op_sel[1] ? {{WIDTH{1'b0}}, rs_abs}
                                                   : {{WIDTH{1'b0}}, rt_abs};
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StCalc;
                    end else begin
                        if (bus.HI_write_enable) hi_q <= bus.HI_input;
                        if (bus.LO_write_enable) lo_q <= bus.LO_input;
                    end
                end
                StCalc: begin
                    acc_q <= div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.HI_output = hi_q;
    assign bus.LO_output = lo_q;
endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
module tb_hi_lo_muldiv_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    hi_lo_muldiv_if #(.WIDTH(32)) bus ();

    hi_lo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op and run it to completion (stimulus only; callers compare).
    task automatic run_op(input logic [1:0] sel, input logic [31:0] rs, input logic [31:0] rt,
                          output int cycles, output int dones, output bit held,
                          output bit done_at_end);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        bus.op_sel   = sel;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.op_start = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        hi0    = bus.HI_output;
        lo0    = bus.LO_output;
        cycles = 0;
        dones  = 0;
        held   = 1'b1;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            if (bus.done === 1'b1) dones++;
            if (bus.HI_output !== hi0 || bus.LO_output !== lo0) held = 1'b0;
            @(negedge clk);
        end
        done_at_end = (bus.done === 1'b1);
        if (bus.done === 1'b1) dones++;
        @(negedge clk);
        if (bus.done === 1'b1) dones++;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (bus.HI_output !== 32'h0 || bus.LO_output !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_hilo: got %h/%h want 0/0", bus.HI_output, bus.LO_output);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.HI_input        = 32'h1234_5678;
        bus.LO_input        = 32'h9ABC_DEF0;
        bus.HI_write_enable = 1'b1;
        bus.LO_write_enable = 1'b1;
        @(negedge clk);
        bus.HI_write_enable = 1'b0;
        bus.LO_write_enable = 1'b0;
        n_cmp++;
        if (bus.HI_output !== 32'h1234_5678 || bus.LO_output !== 32'h9ABC_DEF0) begin
            n_bad++;
            $display("FAIL mthi_mtlo: got %h/%h want 12345678/9abcdef0",
                     bus.HI_output, bus.LO_output);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL mt_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mult;
        int cycles, dones;
        bit held, dend;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, cycles, dones, held, dend);
        n_cmp++;
        if (cycles != 33) begin
            n_bad++;
            $display("FAIL mult_busy_cycles: got %0d want 33", cycles);
        end
        n_cmp++;
        if (bus.HI_output !== 32'hFFFF_FFFF || bus.LO_output !== 32'hFFFF_FFF1) begin
            n_bad++;
            $display("FAIL mult_result: got %h/%h want ffffffff/fffffff1",
                     bus.HI_output, bus.LO_output);
        end
        n_cmp++;
        if (dones != 1 || !dend) begin
            n_bad++;
            $display("FAIL mult_done: got pulses=%0d at_end=%b want 1/1", dones, dend);
        end
        n_cmp++;
        if (!held) begin
            n_bad++;
            $display("FAIL mult_hold: got early HI/LO change want hold until writeback");
        end
    endtask

    task automatic test_multu_div;
        int cycles, dones;
        bit held, dend;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'hFFFF_FFFE || bus.LO_output !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL multu_max: got %h/%h want fffffffe/00000001",
                     bus.HI_output, bus.LO_output);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'hFFFF_FFFF || bus.LO_output !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_neg7_2: got %h/%h want ffffffff/fffffffd",
                     bus.HI_output, bus.LO_output);
        end
        n_cmp++;
        if (cycles != 33) begin
            n_bad++;
            $display("FAIL div_busy_cycles: got %0d want 33", cycles);
        end
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'h0000_0001 || bus.LO_output !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_7_neg2: got %h/%h want 00000001/fffffffd",
                     bus.HI_output, bus.LO_output);
        end
        run_op(2'b11, 32'd100, 32'd7, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'd2 || bus.LO_output !== 32'd14) begin
            n_bad++;
            $display("FAIL divu_100_7: got %h/%h want 00000002/0000000e",
                     bus.HI_output, bus.LO_output);
        end
    endtask

    task automatic test_div_corners;
        int cycles, dones;
        bit held, dend;
        run_op(2'b11, 32'd7, 32'd0, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'd7 || bus.LO_output !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL divu_by0: got %h/%h want 00000007/ffffffff",
                     bus.HI_output, bus.LO_output);
        end
        n_cmp++;
        if (cycles != 33) begin
            n_bad++;
            $display("FAIL div0_busy_cycles: got %0d want 33", cycles);
        end
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'hFFFF_FFFB || bus.LO_output !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL div_by0_signed: got %h/%h want fffffffb/ffffffff",
                     bus.HI_output, bus.LO_output);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'h0 || bus.LO_output !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL div_minneg: got %h/%h want 00000000/80000000",
                     bus.HI_output, bus.LO_output);
        end
    endtask

    task automatic test_start_vs_write;
        int cycles;
        @(negedge clk);
        bus.LO_input        = 32'h0000_5555;
        bus.LO_write_enable = 1'b1;
        @(negedge clk);
        bus.LO_input = 32'h0000_1234;
        bus.op_sel   = 2'b01;
        bus.rs_val   = 32'd2;
        bus.rt_val   = 32'd3;
        bus.op_start = 1'b1;
        @(negedge clk);
        bus.op_start        = 1'b0;
        bus.LO_write_enable = 1'b0;
        n_cmp++;
        if (bus.LO_output !== 32'h0000_5555 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_wins: got LO=%h busy=%b want 00005555/1",
                     bus.LO_output, bus.busy);
        end
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        n_cmp++;
        if (bus.HI_output !== 32'd0 || bus.LO_output !== 32'd6) begin
            n_bad++;
            $display("FAIL multu_2_3: got %h/%h want 00000000/00000006",
                     bus.HI_output, bus.LO_output);
        end
    endtask

    task automatic test_midop_and_gating;
        int cycles;
        @(negedge clk);
        bus.op_sel   = 2'b01;
        bus.rs_val   = 32'h0001_0000;
        bus.rt_val   = 32'h0003_0000;
        bus.op_start = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            if (cycles == 1) begin
                bus.op_sel          = 2'b10;
                bus.rs_val          = 32'hDEAD_BEEF;
                bus.rt_val          = 32'h0;
                bus.HI_input        = 32'hAAAA_AAAA;
                bus.HI_write_enable = 1'b1;
                bus.op_start        = 1'b1;
            end
            if (cycles == 3) begin
                bus.HI_write_enable = 1'b0;
                bus.op_start        = 1'b0;
            end
            if (cycles == 10) bus.clk_enable = 1'b0;
            if (cycles == 15) bus.clk_enable = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (cycles != 38) begin
            n_bad++;
            $display("FAIL gated_busy_cycles: got %0d want 38", cycles);
        end
        n_cmp++;
        if (bus.HI_output !== 32'd3 || bus.LO_output !== 32'd0) begin
            n_bad++;
            $display("FAIL midop_result: got %h/%h want 00000003/00000000",
                     bus.HI_output, bus.LO_output);
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_bad++;
            $display("FAIL midop_done: got %b want 1", bus.done);
        end
        // Freeze right at the done pulse: it must hold until the next enabled edge
        bus.clk_enable = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_hold: got done=%b busy=%b want 1/0", bus.done, bus.busy);
        end
        bus.clk_enable = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_clear: got %b want 0", bus.done);
        end
    endtask

    task automatic test_reset_midop;
        int cycles, dones;
        bit held, dend;
        @(negedge clk);
        bus.op_sel   = 2'b10;
        bus.rs_val   = 32'd1000;
        bus.rt_val   = 32'd3;
        bus.op_start = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.HI_output !== 32'h0 || bus.LO_output !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b done=%b HI=%h LO=%h want 0/0/0/0",
                     bus.busy, bus.done, bus.HI_output, bus.LO_output);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.HI_output !== 32'h0 || bus.LO_output !== 32'h0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got busy=%b HI=%h LO=%h want 0/0/0",
                     bus.busy, bus.HI_output, bus.LO_output);
        end
        run_op(2'b00, 32'd6, 32'd7, cycles, dones, held, dend);
        n_cmp++;
        if (bus.HI_output !== 32'd0 || bus.LO_output !== 32'd42 || cycles != 33) begin
            n_bad++;
            $display("FAIL mult_6_7: got %h/%h cycles=%0d want 00000000/0000002a/33",
                     bus.HI_output, bus.LO_output, cycles);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset               = 1'b0;
        bus.clk_enable      = 1'b1;
        bus.op_start        = 1'b0;
        bus.op_sel          = 2'b00;
        bus.rs_val          = '0;
        bus.rt_val          = '0;
        bus.HI_input        = '0;
        bus.LO_input        = '0;
        bus.HI_write_enable = 1'b0;
        bus.LO_write_enable = 1'b0;
        test_reset();
        test_mult();
        test_multu_div();
        test_div_corners();
        test_start_vs_write();
        test_midop_and_gating();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
